fp_mul_pipe: RTL and testbench
==============================

# fp_mul_pipe

Parametrised, fully pipelined IEEE-754-style floating-point multiplier with valid/ready flow control, tag passthrough and synchronous flush. It is the next generation of the enable-gated multiplier wrapper used in the FFT butterfly datapath. It replaces free-running enable gating with a lossless handshake so butterfly and twiddle schedulers can stall it. It also generalises the format, so single- and reduced-precision FFT builds share one block.

## Interface
- EXP_W, 8, exponent field width
- MAN_W, 23, stored mantissa field width (hidden bit excluded)
- TAG_W, 4, width of sideband tag carried alongside each operand pair
- DATA_W (local, derived), 1+EXP_W+MAN_W
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous; clears all pipeline valid bits
- in_valid  in  1  operand pair present
- in_ready  out  1  block accepts pair this cycle
- in_a  in  DATA_W  operand A
- in_b  in  DATA_W  operand B
- in_tag  in  TAG_W  sideband, returned unchanged with result
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_p  out  DATA_W  product
- out_tag  out  TAG_W  tag of product
- out_flags  out  4  {invalid, overflow, underflow, inexact}; present only with FP_MUL_FLAGS_EN

## Operation
- Three stages, each with its own valid bit:
  - S1: unpack, special-case classification, sign XOR, biased exponent sum minus bias.
  - S2: (MAN_W+1)×(MAN_W+1) mantissa product.
  - S3: normalise (shift 0 or 1), round to nearest even, pack.
- Bias = 2^(EXP_W-1)-1. Exponent arithmetic is signed, EXP_W+2 bits wide, so no wrap.
- Denormal inputs are flushed to signed zero before use (FTZ).
- Denormal or tiny results flush to signed zero and set underflow. Inexact is also set if the result is nonzero-exact.
- NaN in either operand, or inf×0, gives canonical NaN (sign 0, exp all ones, mantissa MSB 1, rest 0) and sets invalid.
- inf×finite-nonzero gives inf with sign XOR.
- Exponent ≥ all-ones after rounding gives signed inf and sets overflow and inexact.
- Zero×finite gives zero with sign XOR.
- A rounding carry out of the mantissa increments the exponent. That increment can itself cause overflow.

## Timing
- advance = !out_valid | out_ready; in_ready = advance. The whole pipe moves together and bubbles are not squeezed.
- A transfer happens when in_valid & in_ready. The result appears at out_valid exactly 3 advancing cycles later. Latency is 3 cycles with no stall.
- Throughput is 1 result/cycle while out_ready=1.
- While out_valid & !out_ready:
  - out_p, out_tag and out_flags hold stable.
  - All stages hold.
  - in_ready=0.
- flush=1 clears every valid bit next edge and has priority over advance. A transfer presented in the same cycle is discarded. in_ready still reflects advance.
- Reset values: out_valid=0, out_p=0, out_tag=0, out_flags=0, and all stage valids 0. in_ready reads 1 once reset is released.
- Reset asserted mid-operation drops all in-flight data. No partial result is emitted after release.
- Data registers are loaded only on advance. Valid registers are the only ones that must clear.

## Configuration
- FP_MUL_FLAGS_EN defined:
  - out_flags port exists.
  - Flags are computed in S1/S3 and pipelined with data, then sticky-free, per result.
- FP_MUL_FLAGS_EN undefined:
  - Port and flag logic are absent.
  - Special-value results are unchanged.

## Structure
- Shared package fp_pkg holds:
  - the flag bit index constants (FLG_INVALID=3, FLG_OVERFLOW=2, FLG_UNDERFLOW=1, FLG_INEXACT=0);
  - the operand class enum (ZERO, NORM, INF, NAN);
  - the function computing bias from EXP_W.
- One sub-module, fp_mul_round: purely combinational S3 normalise/round/pack. It is unit-testable alone.

## Test plan
All values below are EXP_W=8, MAN_W=23.
- Basic multiply: 0x3FC00000 × 0x40000000, tag 5 → out_p 0x40400000, tag 5, 3 cycles after acceptance, flags 0.
- Rounding: 0x3F800001 × 0x3F800001 → 0x3F800002, inexact=1.
- Invalid: 0x7F800000 × 0x00000000 → 0x7FC00000, invalid=1.
- Overflow: 0x7F7FFFFF × 0xC0000000 → 0xFF800000, overflow=1.
- Flush-to-zero:
  - 0x00400000 × 0x3F800000 → 0x00000000.
  - 0x00800000 × 0x3F000000 → 0x00000000, underflow=1.
- Back-pressure:
  - Stream 8 pairs with out_ready toggling randomly and a flush pulse mid-stream. All pre-flush accepted results emerge in order, with none lost or duplicated.
  - Output stays stable while stalled, and no post-flush ghost results appear.
  - Assert rst_n low with 3 in flight → out_valid=0 immediately, and nothing emitted after release.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: flag bit positions, operand classes, bias helper.
package fp_pkg;

    localparam int FLG_INVALID   = 3;
    localparam int FLG_OVERFLOW  = 2;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_INEXACT   = 0;

    typedef enum logic [1:0] {
        ZERO,
        NORM,
        INF,
        NAN
    } fp_class_e;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/fp_mul_round.sv
// Combinational normalise / round-to-nearest-even / pack of a raw mantissa product.
// Flag output exists only when FP_MUL_FLAGS_EN is defined.
module fp_mul_round
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  fp_class_e                 cls_i,
    input  logic                      sign_i,
    input  logic signed [EXP_W+1:0]   exp_i,
    input  logic [2*MAN_W+1:0]        prod_i,
    output logic [EXP_W+MAN_W:0]      p_o
`ifdef FP_MUL_FLAGS_EN
    ,
    output logic [3:0]                flags_o
`endif
);

    localparam int PW = 2 * MAN_W + 2;
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

    logic                   top;
    logic [PW-2:0]          nrm;
    logic [MAN_W-1:0]       man;
    logic                   guard;
    logic                   sticky;
    logic                   rnd;
    logic [MAN_W:0]         man_r;
    logic signed [EW-1:0]   exp_n;
    logic                   ovf;
    logic                   unf;

    always_comb begin
        top    = prod_i[PW-1];
        // Product lies in [1,4); left-align so the hidden bit is dropped at nrm[PW-1].
        nrm    = top ? prod_i[PW-2:0] : {prod_i[PW-3:0], 1'b0};
        man    = nrm[PW-2 -: MAN_W];
        guard  = nrm[MAN_W];
        sticky = |nrm[MAN_W-1:0];
        rnd    = guard & (sticky | man[0]);
        man_r  = {1'b0, man} + {{MAN_W{1'b0}}, rnd};
        exp_n  = exp_i + $signed({{(EW-1){1'b0}}, top}) + $signed({{(EW-1){1'b0}}, man_r[MAN_W]});
        ovf    = (exp_n >= EXP_MAX);
        unf    = (exp_n <= 0);
    end

    always_comb begin
        p_o = {sign_i, {(EXP_W + MAN_W){1'b0}}};
        case (cls_i)
            NAN:  p_o = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
            INF:  p_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ZERO: p_o = {sign_i, {(EXP_W + MAN_W){1'b0}}};
            default: begin
                if (ovf)
                    p_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                else if (!unf)
                    p_o = {sign_i, exp_n[EXP_W-1:0], man_r[MAN_W-1:0]};
            end
        endcase
    end

`ifdef FP_MUL_FLAGS_EN
    always_comb begin
        flags_o = 4'b0000;
        if (cls_i == NAN) begin
            flags_o[FLG_INVALID] = 1'b1;
        end else if (cls_i == NORM) begin
            flags_o[FLG_OVERFLOW]  = ovf;
            flags_o[FLG_UNDERFLOW] = unf;
            flags_o[FLG_INEXACT]   = ovf | unf | guard | sticky;
        end
    end
`endif

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined FP multiplier (FTZ, round-to-nearest-even) with valid/ready and flush.
// Define FP_MUL_FLAGS_EN to add the per-result out_flags port.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4,
    localparam int DATA_W = 1 + EXP_W + MAN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_p,
    output logic [TAG_W-1:0]  out_tag
`ifdef FP_MUL_FLAGS_EN
    ,
    output logic [3:0]        out_flags
`endif
);

    localparam int EW   = EXP_W + 2;
    localparam int SW   = MAN_W + 1;
    localparam int BIAS = fp_bias(EXP_W);

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        if (e == '0) return ZERO;
        if (&e) return (m == '0) ? INF : NAN;
        return NORM;
    endfunction

    // Handshake: a pair transfers when in_valid & in_ready; a result transfers when
    // out_valid & out_ready. The whole pipe advances in lockstep whenever the output
    // slot is empty or being consumed, so in_ready equals that advance condition.
    logic advance;
    logic v1_q, v2_q, v3_q;

    fp_class_e              cls_a, cls_b, cls1_d, cls1_q, cls2_q;
    logic                   sign1_d, sign1_q, sign2_q;
    logic signed [EW-1:0]   exp1_d, exp1_q, exp2_q;
    logic [SW-1:0]          ma1_q, mb1_q;
    logic [2*SW-1:0]        prod2_q;
    logic [TAG_W-1:0]       tag1_q, tag2_q, tag3_q;
    logic [DATA_W-1:0]      p3_d, p3_q;

    assign advance   = !v3_q | out_ready;
    assign in_ready  = advance;
    assign out_valid = v3_q;
    assign out_p     = p3_q;
    assign out_tag   = tag3_q;

    always_comb begin
        cls_a   = classify(in_a[DATA_W-2 -: EXP_W], in_a[MAN_W-1:0]);
        cls_b   = classify(in_b[DATA_W-2 -: EXP_W], in_b[MAN_W-1:0]);
        sign1_d = in_a[DATA_W-1] ^ in_b[DATA_W-1];
        exp1_d  = {2'b00, in_a[DATA_W-2 -: EXP_W]} + {2'b00, in_b[DATA_W-2 -: EXP_W]} - EW'(BIAS);
        if (cls_a == NAN || cls_b == NAN ||
            (cls_a == INF && cls_b == ZERO) || (cls_a == ZERO && cls_b == INF))
            cls1_d = NAN;
        else if (cls_a == INF || cls_b == INF)
            cls1_d = INF;
        else if (cls_a == ZERO || cls_b == ZERO)
            cls1_d = ZERO;
        else
            cls1_d = NORM;
    end

    // Flush outranks advance; only the valid bits need clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else if (flush) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else if (advance) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            cls1_q  <= cls1_d;
            sign1_q <= sign1_d;
            exp1_q  <= exp1_d;
            ma1_q   <= {1'b1, in_a[MAN_W-1:0]};
            mb1_q   <= {1'b1, in_b[MAN_W-1:0]};
            tag1_q  <= in_tag;
            cls2_q  <= cls1_q;
            sign2_q <= sign1_q;
            exp2_q  <= exp1_q;
            prod2_q <= {{SW{1'b0}}, ma1_q} * {{SW{1'b0}}, mb1_q};
            tag2_q  <= tag1_q;
        end
    end

`ifdef FP_MUL_FLAGS_EN
    logic [3:0] flags3_d, flags3_q;
    assign out_flags = flags3_q;
`endif

    fp_mul_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .cls_i   (cls2_q),
        .sign_i  (sign2_q),
        .exp_i   (exp2_q),
        .prod_i  (prod2_q),
        .p_o     (p3_d)
`ifdef FP_MUL_FLAGS_EN
        ,
        .flags_o (flags3_d)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p3_q     <= '0;
            tag3_q   <= '0;
`ifdef FP_MUL_FLAGS_EN
            flags3_q <= '0;
`endif
        end else if (advance) begin
            p3_q     <= p3_d;
            tag3_q   <= tag2_q;
`ifdef FP_MUL_FLAGS_EN
            flags3_q <= flags3_d;
`endif
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe (binary32): directed vectors, scoreboard queue, stall/flush/reset cases.
// Flag checks are compiled in only when FP_MUL_FLAGS_EN is defined.
module tb_fp_mul_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_p;
    logic [3:0]  out_tag;
`ifdef FP_MUL_FLAGS_EN
    logic [3:0]  out_flags;
`endif

    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_INX  = 4'b0001;
    localparam logic [3:0] F_UNF  = 4'b0011;
    localparam logic [3:0] F_OVF  = 4'b0101;
    localparam logic [3:0] F_INV  = 4'b1000;

    logic [39:0] exp_q[$];
    int          tests;
    int          fails;
    logic        rand_ready;
    logic        have_hold;
    logic [35:0] held;

    fp_mul_pipe #(
        .EXP_W (8),
        .MAN_W (23),
        .TAG_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_tag   (out_tag)
`ifdef FP_MUL_FLAGS_EN
        ,
        .out_flags (out_flags)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks hold stability.
    always @(negedge clk) begin
        logic [39:0] e;
        if (!rst_n || !out_valid) begin
            have_hold = 1'b0;
        end else begin
            if (have_hold) check("stall_stable", {out_p, out_tag}, held);
            if (out_ready) begin
                have_hold = 1'b0;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got p=%h tag=%h, required no result", out_p, out_tag);
                end else begin
                    e = exp_q.pop_front();
                    check("result_p", out_p, e[39:8]);
                    check("result_tag", out_tag, e[7:4]);
`ifdef FP_MUL_FLAGS_EN
                    check("result_flags", out_flags, e[3:0]);
`endif
                end
            end else begin
                have_hold = 1'b1;
                held      = {out_p, out_tag};
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                        input logic [31:0] p, input logic [3:0] f);
        logic ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            ok = in_ready;
            if (ok && !flush) exp_q.push_back({p, tag, f});
            step();
            if (ok) break;
        end
        if (!ok) check("accept_timeout", 64'(ok), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) step();
        repeat (5) step();
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        int lat;
        tests      = 0;
        fails      = 0;
        rand_ready = 1'b0;
        have_hold  = 1'b0;
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        in_tag     = '0;
        out_ready  = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_out_p", 64'(out_p), 64'(0));
        check("reset_out_tag", 64'(out_tag), 64'(0));
`ifdef FP_MUL_FLAGS_EN
        check("reset_out_flags", 64'(out_flags), 64'(0));
`endif
        rst_n = 1'b1;
        step();
        check("reset_in_ready", 64'(in_ready), 64'(1));

        // Latency of the basic multiply.
        send(32'h3FC00000, 32'h40000000, 4'd5, 32'h40400000, F_NONE);
        lat = 1;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        check("latency", 64'(lat), 64'(3));
        drain();

        // Directed special cases, back to back.
        send(32'h3F800001, 32'h3F800001, 4'd1, 32'h3F800002, F_INX);
        send(32'h7F800000, 32'h00000000, 4'd2, 32'h7FC00000, F_INV);
        send(32'h7FC00000, 32'h3F800000, 4'd3, 32'h7FC00000, F_INV);
        send(32'h7F7FFFFF, 32'hC0000000, 4'd4, 32'hFF800000, F_OVF);
        send(32'h7F7FFFFE, 32'h3F800001, 4'd6, 32'h7F800000, F_OVF);
        send(32'h00400000, 32'h3F800000, 4'd7, 32'h00000000, F_NONE);
        send(32'h00800000, 32'h3F000000, 4'd8, 32'h00000000, F_UNF);
        send(32'h3FFFFFFE, 32'h3F800001, 4'd9, 32'h40000000, F_INX);
        send(32'h3FFFFFFF, 32'h3FFFFFFF, 4'd10, 32'h407FFFFE, F_INX);
        send(32'h7F800000, 32'hC0000000, 4'd11, 32'hFF800000, F_NONE);
        send(32'h00000000, 32'hC0000000, 4'd12, 32'h80000000, F_NONE);
        drain();

        // Explicit stall: output must hold and input must be refused.
        out_ready = 1'b0;
        send(32'h40000000, 32'h40000000, 4'd1, 32'h40800000, F_NONE);
        send(32'h3F800000, 32'hBF800000, 4'd2, 32'hBF800000, F_NONE);
        repeat (3) step();
        check("stall_out_valid", 64'(out_valid), 64'(1));
        check("stall_in_ready", 64'(in_ready), 64'(0));
        step();
        drain();

        // Random back-pressure stream with a flush in the middle.
        rand_ready = 1'b1;
        send(32'h40400000, 32'h40400000, 4'd1, 32'h41100000, F_NONE);
        send(32'h3F000000, 32'h3E800000, 4'd2, 32'h3E000000, F_NONE);
        send(32'hC0A00000, 32'h40000000, 4'd3, 32'hC1200000, F_NONE);
        send(32'h3FC00000, 32'h40000000, 4'd4, 32'h40400000, F_NONE);
        flush = 1'b1;
        @(posedge clk);
        exp_q.delete();
        #1;
        flush = 1'b0;
        send(32'h40000000, 32'h40000000, 4'd5, 32'h40800000, F_NONE);
        send(32'h3F800001, 32'h3F800001, 4'd6, 32'h3F800002, F_INX);
        send(32'h00000000, 32'hC0000000, 4'd7, 32'h80000000, F_NONE);
        send(32'h3F800000, 32'hBF800000, 4'd8, 32'hBF800000, F_NONE);
        rand_ready = 1'b0;
        drain();

        // Reset with the pipe full: everything in flight is dropped.
        out_ready = 1'b0;
        send(32'h40000000, 32'h40000000, 4'd1, 32'h40800000, F_NONE);
        send(32'h40400000, 32'h40400000, 4'd2, 32'h41100000, F_NONE);
        send(32'h3FC00000, 32'h40000000, 4'd3, 32'h40400000, F_NONE);
        check("full_out_valid", 64'(out_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset_out_valid", 64'(out_valid), 64'(0));
        step();
        step();
        rst_n = 1'b1;
        check("post_reset_in_ready", 64'(in_ready), 64'(1));
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
